// File: rtl/ex_wb_stage.sv
// EX/WB stage: write-back select, relative jump resolve with
// wrong-path squash, EX/WB register and saturating retire count.
module ex_wb_stage #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int SQUASH_SLOTS = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PC_ID_EX,
  input  logic [ADDR_W-1:0] RegRd_ID_EX,
  input  logic [DATA_W-1:0] imm_ID_EX,
  input  logic [DATA_W-1:0] relAdd_ID_EX,
  input  logic              RegWrite_ID_EX,
  input  logic              jumpIns_ID_EX,
  input  logic              valueToReg_ID_EX,
  input  logic [DATA_W-1:0] Data1_ID_EX,
  output logic              PCSrc,
  output logic [DATA_W-1:0] jumpTarget,
  output logic              RegWrite_WB,
  output logic [ADDR_W-1:0] RegRd_WB,
  output logic [DATA_W-1:0] WriteData_WB,
  output logic              squashing,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_SLOTS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_sq;
  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wd;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_valid;
  logic              w_take;
  logic [DATA_W-1:0] w_wdata;

  assign w_valid = (r_sq == 2'd0);
  assign w_take  = w_valid & jumpIns_ID_EX;
  assign w_wdata = valueToReg_ID_EX ? imm_ID_EX
                                    : Data1_ID_EX;

  assign PCSrc        = w_take;
  assign jumpTarget   = PC_ID_EX + relAdd_ID_EX;
  assign squashing    = ~w_valid;
  assign RegWrite_WB  = r_we;
  assign RegRd_WB     = r_rd;
  assign WriteData_WB = r_wd;
  assign retired      = r_cnt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_sq  <= 2'd0;
      r_we  <= 1'b0;
      r_rd  <= '0;
      r_wd  <= '0;
      r_cnt <= '0;
    end else begin
      r_we <= w_valid & RegWrite_ID_EX;
      r_rd <= RegRd_ID_EX;
      r_wd <= w_wdata;
      // squashed slots neither retire nor reload the window
      if (w_valid && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      if (w_take)
        r_sq <= SQ_LOAD;
      else if (r_sq != 2'd0)
        r_sq <= r_sq - 2'd1;
    end
  end

endmodule
